// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: FIFO controller that sequences a simple dual-port RAM with a registered read port.
// The optional sticky ovf/udf error flags and the err_clr input are built only when FIFO_CTRL_ERR_EN is defined.
module fifo_ram_ctrl #(
   parameter int L     = 8,
   parameter int DW    = 6,
   parameter int AF_TH = 2**L - 4,
   parameter int AE_TH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr,
   input  logic [DW-1:0] i_wdat,
   input  logic          i_rd,
   output logic [L-1:0]  o_ram_aa,
   output logic [DW-1:0] o_ram_ad,
   output logic          o_ram_aw,
   output logic [L-1:0]  o_ram_ba,
   output logic          o_ram_br,
   input  logic [DW-1:0] i_ram_bd,
   output logic [DW-1:0] o_dout,
   output logic          o_dout_vld,
   output logic [L:0]    o_cnt,
`ifdef FIFO_CTRL_ERR_EN
   output logic          o_ovf,
   output logic          o_udf,
   input  logic          i_err_clr,
`endif
   output logic          o_full,
   output logic          o_empty,
   output logic          o_afull,
   output logic          o_aempty
);
   localparam logic [L:0] LP_DEPTH = (L+1)'(2**L);
   localparam logic [L:0] LP_AF    = (L+1)'(AF_TH);
   localparam logic [L:0] LP_AE    = (L+1)'(AE_TH);

   logic [L:0] r_wp, r_rp, r_cnt, w_cnt_nxt;
   logic       r_full, r_empty, r_afull, r_aempty, r_dout_vld;
   logic       w_wr_acc, w_rd_acc;

   // Accept requests against the registered flags; RAM enables are held low during reset
   always_comb begin
      w_wr_acc  = i_wr && !r_full && !i_rst;
      w_rd_acc  = i_rd && !r_empty && !i_rst;
      w_cnt_nxt = (w_wr_acc && !w_rd_acc) ? r_cnt + 1'b1 :
                  (w_rd_acc && !w_wr_acc) ? r_cnt - 1'b1 : r_cnt;
   end

   // Pointers, occupancy, flags and read-valid strobe
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_cnt      <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_afull    <= 1'b0;
         r_aempty   <= 1'b1;
         r_dout_vld <= 1'b0;
      end else begin
         r_wp       <= w_wr_acc ? r_wp + 1'b1 : r_wp;
         r_rp       <= w_rd_acc ? r_rp + 1'b1 : r_rp;
         r_cnt      <= w_cnt_nxt;
         r_full     <= w_cnt_nxt == LP_DEPTH;
         r_empty    <= w_cnt_nxt == '0;
         r_afull    <= w_cnt_nxt >= LP_AF;
         r_aempty   <= w_cnt_nxt <= LP_AE;
         r_dout_vld <= w_rd_acc;
      end
   end

`ifdef FIFO_CTRL_ERR_EN
   logic r_ovf, r_udf;

   // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (i_wr && r_full)  ? 1'b1 : i_err_clr ? 1'b0 : r_ovf;
         r_udf <= (i_rd && r_empty) ? 1'b1 : i_err_clr ? 1'b0 : r_udf;
      end
   end

   assign o_ovf = r_ovf;
   assign o_udf = r_udf;
`endif

   assign o_ram_aw   = w_wr_acc;
   assign o_ram_aa   = r_wp[L-1:0];
   assign o_ram_ad   = i_wdat;
   assign o_ram_br   = w_rd_acc;
   assign o_ram_ba   = r_rp[L-1:0];
   assign o_dout     = i_ram_bd;
   assign o_dout_vld = r_dout_vld;
   assign o_cnt      = r_cnt;
   assign o_full     = r_full;
   assign o_empty    = r_empty;
   assign o_afull    = r_afull;
   assign o_aempty   = r_aempty;
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb_fifo_ram_ctrl: scoreboard bench for fifo_ram_ctrl with a behavioural registered-read RAM.
module tb_fifo_ram_ctrl;
   localparam int L = 3, DW = 6, AF_TH = 6, AE_TH = 1, DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr = 1'b0, rd = 1'b0;
   logic [DW-1:0] wdat = '0;
   logic [L-1:0]  ram_aa, ram_ba;
   logic [DW-1:0] ram_ad, ram_bd, dout;
   logic          ram_aw, ram_br, dout_vld;
   logic [L:0]    cnt;
   logic          full, empty, afull, aempty;
`ifdef FIFO_CTRL_ERR_EN
   logic          ovf, udf;
   logic          err_clr = 1'b0;
`endif

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] q[$];
   int            checks = 0, failures = 0;
   int            m_cnt = 0;
   logic [L:0]    m_wp = '0, m_rp = '0;
   logic          m_vld = 1'b0;
   logic [L-1:0]  last_aa = '0;
   logic          saw_wrap = 1'b0;

   fifo_ram_ctrl #(.L(L), .DW(DW), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
      .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wdat(wdat), .i_rd(rd),
      .o_ram_aa(ram_aa), .o_ram_ad(ram_ad), .o_ram_aw(ram_aw),
      .o_ram_ba(ram_ba), .o_ram_br(ram_br), .i_ram_bd(ram_bd),
      .o_dout(dout), .o_dout_vld(dout_vld), .o_cnt(cnt),
`ifdef FIFO_CTRL_ERR_EN
      .o_ovf(ovf), .o_udf(udf), .i_err_clr(err_clr),
`endif
      .o_full(full), .o_empty(empty), .o_afull(afull), .o_aempty(aempty)
   );

   always #5 clk = ~clk;

   // Simple dual-port RAM with a registered read port
   always @(posedge clk) begin
      if (ram_aw) mem[ram_aa] <= ram_ad;
      if (ram_br) ram_bd <= mem[ram_ba];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic chk_status();
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("afull", 32'(afull), 32'(m_cnt >= AF_TH));
      chk("aempty", 32'(aempty), 32'(m_cnt <= AE_TH));
      chk("dout_vld", 32'(dout_vld), 32'(m_vld));
      if (dout_vld) begin
         if (q.size() == 0) chk("sb_underrun", 32'(1), 32'(0));
         else chk("dout", 32'(dout), 32'(q.pop_front()));
      end
   endtask

   // One clock of stimulus, driven just after a falling edge and checked on the next one
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      logic ew, er;
      wr = w; rd = r; wdat = d;
      #1;
      ew = w && (m_cnt < DEPTH);
      er = r && (m_cnt > 0);
      chk("ram_aw", 32'(ram_aw), 32'(ew));
      chk("ram_br", 32'(ram_br), 32'(er));
      if (ew) begin
         chk("ram_aa", 32'(ram_aa), 32'(m_wp[L-1:0]));
         chk("ram_ad", 32'(ram_ad), 32'(d));
         if (last_aa == 3'd7 && ram_aa == 3'd0) saw_wrap = 1'b1;
         last_aa = ram_aa;
         q.push_back(d);
      end
      if (er) chk("ram_ba", 32'(ram_ba), 32'(m_rp[L-1:0]));
      @(posedge clk);
      m_cnt = m_cnt + (ew ? 1 : 0) - (er ? 1 : 0);
      if (ew) m_wp = m_wp + 1'b1;
      if (er) m_rp = m_rp + 1'b1;
      m_vld = er;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      chk_status();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, '0);
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
      step(1'b1, 1'b0, 6'h3F);
`ifdef FIFO_CTRL_ERR_EN
      chk("ovf", 32'(ovf), 32'(1));
`endif
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
`ifdef FIFO_CTRL_ERR_EN
      chk("udf", 32'(udf), 32'(1));
`endif
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
      step(1'b1, 1'b1, 6'h2E);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 6'h21);
      chk("wr_rd_empty_vld", 32'(dout_vld), 32'(0));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h22 + i));
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'(8'h30 + i));
      chk("aa_wrap", 32'(saw_wrap), 32'(1));
      step(1'b1, 1'b0, 6'h3A);
      chk("cnt_before_rst", 32'(cnt), 32'(5));
      rd = 1'b1;
      #1;
      chk("rst_rd_br", 32'(ram_br), 32'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_ram_br", 32'(ram_br), 32'(0));
      rd = 1'b0;
      q.delete();
      m_cnt = 0; m_wp = '0; m_rp = '0; m_vld = 1'b0;
      chk_status();
`ifdef FIFO_CTRL_ERR_EN
      chk("rst_ovf", 32'(ovf), 32'(0));
      chk("rst_udf", 32'(udf), 32'(0));
`endif
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 6'h15);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      chk("sb_drained", 32'(q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_ram_ctrl.md
# fifo_ram_ctrl

Single-clock FIFO controller that sequences a simple dual-port block RAM (one write port, one registered read port, L-bit address, DW-bit data) as a 2^L-entry first-in/first-out buffer. It owns the write/read pointers, occupancy count and status flags, and drives both RAM ports directly. Read data comes back from the RAM one cycle after an accepted read and is qualified by a valid strobe.

## Interface
Parameters:
- L, 8, RAM address width; FIFO depth = 2^L
- DW, 6, data width
- AF_TH, 2^L-4, almost-full threshold (afull when count >= AF_TH); legal range 1..2^L
- AE_TH, 4, almost-empty threshold (aempty when count <= AE_TH); legal range 0..2^L-1

Ports:
- clk  in  1  clock; all state is updated on the rising edge, and the RAM's ac/bc are tied to this clock
- rst  in  1  asynchronous, active-high reset
- wr  in  1  write request
- wdat  in  DW  write data
- rd  in  1  read request
- ram_aa  out  L  RAM write address
- ram_ad  out  DW  RAM write data (= wdat)
- ram_aw  out  1  RAM write enable
- ram_ba  out  L  RAM read address
- ram_br  out  1  RAM read enable
- ram_bd  in  DW  RAM read data (registered inside the RAM)
- dout  out  DW  FIFO read data (= ram_bd)
- dout_vld  out  1  dout valid; one cycle per accepted read
- cnt  out  L+1  occupancy, 0..2^L
- full, empty, afull, aempty  out  1  status flags, all registered
- ovf, udf  out  1  sticky overflow/underflow flags (only with FIFO_CTRL_ERR_EN)
- err_clr  in  1  synchronous clear of ovf/udf (only with FIFO_CTRL_ERR_EN)

## Operation
- Pointers wp and rp are L+1 bits wide. The RAM address is ptr[L-1:0]. Pointers wrap naturally modulo 2^(L+1).
- A write is accepted when wr && !full:
  - ram_aw=1, ram_aa=wp[L-1:0], ram_ad=wdat (combinational).
  - wp increments.
- A read is accepted when rd && !empty:
  - ram_br=1, ram_ba=rp[L-1:0] (combinational).
  - rp increments.
- full and empty are the registered flags of the current cycle. Consequences:
  - When full, a simultaneous wr+rd accepts only the read.
  - When empty, a simultaneous wr+rd accepts only the write. There is no write-to-read bypass.
- cnt next value: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
- Flags are registered from the next cnt value:
  - full = (cnt==2^L)
  - empty = (cnt==0)
  - afull = (cnt>=AF_TH)
  - aempty = (cnt<=AE_TH)
- A rejected request has no side effects. The RAM enable stays 0 and the pointers do not move.
- Reset values: wp=rp=0, cnt=0, empty=1, aempty=1, full=0, afull=0, dout_vld=0, ovf=udf=0.
- Asserting rst mid-operation discards the contents immediately. RAM contents are not cleared, but they are unreachable after reset.
- ram_aw and ram_br are forced to 0 while rst is high.

## Timing
- Write to empty deassertion: empty falls in the cycle after the accepted-write edge. Read is possible from that cycle on.
- Read latency is 1 cycle. A read accepted at edge N gives dout_vld=1 and valid dout during cycle N+1.
- dout_vld is registered: it is the accepted read of the previous cycle, cleared by rst.
- Sustained throughput is one write and one read per cycle.
- Flag latency matches cnt: all flags change on the same edge as cnt.

## Configuration
- FIFO_CTRL_ERR_EN defined:
  - ovf sets on wr && full. udf sets on rd && empty.
  - Both flags are sticky and registered.
  - They are cleared by rst or by err_clr. If a set condition and err_clr occur in the same cycle, set wins.
- FIFO_CTRL_ERR_EN undefined:
  - The ovf, udf and err_clr ports are absent.
  - No error logic is compiled. All other behaviour is identical.

## Test plan
With L=3, DW=6, AF_TH=6, AE_TH=1:
- Reset then idle -> cnt=0, empty=1, aempty=1, full=0, afull=0, dout_vld=0, ram_aw=ram_br=0.
- Write 8 words 0x01..0x08 on consecutive cycles -> cnt reaches 8, afull rises after the 6th write, full rises after the 8th. A 9th write gives ram_aw=0 and cnt stays 8 (ovf=1 with the macro).
- Read 8 words back -> dout_vld pulses one cycle after each read, dout=0x01..0x08 in order, empty=1 at the end. A 9th read gives ram_br=0 (udf=1 with the macro).
- Simultaneous wr+rd at cnt=8 -> only the read is accepted, cnt=7, full=0. Simultaneous wr+rd at cnt=0 -> only the write is accepted, cnt=1, dout_vld=0 next cycle.
- 20 cycles of wr+rd at cnt=4, with the pointers wrapping past address 7 -> cnt stays 4, output data order preserved, ram_aa/ram_ba wrap 7->0.
- Assert rst at cnt=5 with a read in flight -> dout_vld=0 and the flags return to reset values immediately. The next write/read pair returns the new data through address 0.
